fetch_unit: RTL and testbench

Instruction fetch stage for the RV32I core: the producer of the instruction word the decode stage consumes. It owns the fetch PC and issues word requests to instruction memory over a valid/ready request channel. It collects in-order responses into a small instruction buffer and presents `{pc, instruction}` to decode over a valid/ready handshake. On a branch/jump redirect it flushes the buffer and discards stale in-flight responses.

---
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the fetch PC, issues credit-limited word requests,
// buffers in-order responses for decode and discards stale responses after a redirect.
// Optional `FETCH_MISALIGN_EN adds o_misaligned and halts fetch on misaligned redirect targets.
module fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        o_misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q, outst_q, drop_q, outst_d;
  logic [31:0]     fetch_pc_q, resp_pc_q;
  logic            run_q;
  logic            blk;
  logic [31:0]     tgt;
  logic            free, issue, rv, push, pop;
  logic [CW:0]     used;

`ifdef FETCH_MISALIGN_EN
  logic mis_q;
  assign blk          = mis_q;
  assign tgt          = i_redirect_pc;
  assign o_misaligned = mis_q;
`else
  assign blk = 1'b0;
  assign tgt = {i_redirect_pc[31:2], 2'b00};
`endif

  // A slot decode drains this cycle can be re-credited now; this keeps one
  // instruction per cycle with DEPTH=2 while a response still never meets a full buffer.
  assign free  = (cnt_q != '0) && i_inst_ready;
  assign used  = {1'b0, outst_q} + {1'b0, cnt_q} - (CW+1)'(free);
  assign o_imem_req  = run_q && !blk && (used < (CW+1)'(DEPTH));
  assign o_imem_addr = fetch_pc_q;

  assign issue   = o_imem_req && i_imem_ready;
  assign rv      = i_imem_rvalid && (outst_q != '0);
  assign push    = rv && (drop_q == '0) && !i_redirect;
  assign outst_d = outst_q + CW'(issue) - CW'(rv);

  assign o_inst_valid = (cnt_q != '0) && !i_redirect;
  assign o_inst       = (cnt_q != '0) ? fifo_q[rd_q].inst : 32'h0;
  assign o_inst_pc    = (cnt_q != '0) ? fifo_q[rd_q].pc   : 32'h0;
  assign pop          = o_inst_valid && i_inst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      outst_q    <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
`ifdef FETCH_MISALIGN_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      run_q   <= 1'b1;
      outst_q <= outst_d;
      if (issue) fetch_pc_q <= fetch_pc_q + 32'd4;
      if (i_redirect) begin
        // Everything in flight after this edge, including a request taken now, is stale.
        fetch_pc_q <= tgt;
        resp_pc_q  <= tgt;
        drop_q     <= outst_d;
        cnt_q      <= '0;
        wr_q       <= '0;
        rd_q       <= '0;
`ifdef FETCH_MISALIGN_EN
        mis_q      <= (i_redirect_pc[1:0] != 2'b00);
`endif
      end else begin
        if (rv && (drop_q != '0)) drop_q <= drop_q - CW'(1);
        if (push) begin
          wr_q      <= wr_q + AW'(1);
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (pop) rd_q <= rd_q + AW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload needs no reset: it is only visible while the occupancy count is nonzero.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_q] <= '{pc: resp_pc_q, inst: i_imem_rdata};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of per-cycle vectors plus hand sequences
// for stall, redirect-with-inflight, reset and misaligned-redirect corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready;
`ifdef FETCH_MISALIGN_EN
  logic        o_misaligned;
`endif

  fetch_unit #(.RESET_ADDR(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_ready(i_imem_ready),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
    .i_inst_ready(i_inst_ready)
`ifdef FETCH_MISALIGN_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic        junk;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  vec_t  tbl[20];
  int    cyc, lat, total, bad;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic ir, input logic rd, input logic [31:0] rpc,
                              input logic junk, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.ir = ir; v.rd = rd; v.rpc = rpc; v.junk = junk;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // One cycle: log last cycle's accepted request, advance, drive memory + inputs, settle.
  task automatic tick(input logic ir, input logic rd, input logic [31:0] rpc, input logic junk);
    mreq_t m;
    if (o_imem_req && i_imem_ready) begin
      m.a = o_imem_addr; m.due = cyc + 1 + (lat - 1);
      mq.push_back(m);
    end
    @(negedge clk);
    cyc++;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = 32'h0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = mdata(mq[0].a);
      mq.delete(0);
    end else if (junk) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = 32'hDEAD_BEEF;
    end
    i_inst_ready  = ir;
    i_redirect    = rd;
    i_redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_head(input string nm, input logic ev, input logic [31:0] epc);
    chk({nm, ".vld"}, {31'h0, o_inst_valid}, {31'h0, ev});
    if (ev) begin
      chk({nm, ".pc"}, o_inst_pc, epc);
      chk({nm, ".inst"}, o_inst, mdata(epc));
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_imem_ready = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
    i_redirect = 1'b0; i_redirect_pc = 32'h0; i_inst_ready = 1'b0;
    mq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    bit          found;
    logic [31:0] fpc;
    total = 0; bad = 0; lat = 1;
    rst = 1'b0;

    // Steady fetch with a junk response at outstanding==0, a 5-cycle stall, and a wrap redirect.
    tbl[0]  = mk(1, 0, 0, 1, 1, 32'h0,  0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 1, 32'h4,  0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 1, 32'h8,  1, 32'h0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 32'hC,  1, 32'h4);
    tbl[4]  = mk(1, 0, 0, 0, 1, 32'h10, 1, 32'h8);
    tbl[5]  = mk(1, 0, 0, 0, 1, 32'h14, 1, 32'hC);
    tbl[6]  = mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10);
    tbl[7]  = mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10);
    tbl[8]  = mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10);
    tbl[9]  = mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10);
    tbl[10] = mk(0, 0, 0, 0, 0, 32'h18, 1, 32'h10);
    tbl[11] = mk(1, 0, 0, 0, 1, 32'h18, 1, 32'h10);
    tbl[12] = mk(1, 0, 0, 0, 1, 32'h1C, 1, 32'h14);
    tbl[13] = mk(1, 0, 0, 0, 1, 32'h20, 1, 32'h18);
    tbl[14] = mk(1, 1, 32'hFFFF_FFF8, 0, 1, 32'h24, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    tbl[17] = mk(1, 0, 0, 0, 1, 32'h0,  1, 32'hFFFF_FFF8);
    tbl[18] = mk(1, 0, 0, 0, 1, 32'h4,  1, 32'hFFFF_FFFC);
    tbl[19] = mk(1, 0, 0, 0, 1, 32'h8,  1, 32'h0);

    do_reset();
    // Bench reset drive is already released here; re-assert to look at reset values.
    rst = 1'b0; #1;
    chk("rst.req",  {31'h0, o_imem_req},   32'h0);
    chk("rst.addr", o_imem_addr,           32'h0);
    chk("rst.vld",  {31'h0, o_inst_valid}, 32'h0);
    chk("rst.inst", o_inst,                32'h0);
    chk("rst.pc",   o_inst_pc,             32'h0);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      tick(tbl[i].ir, tbl[i].rd, tbl[i].rpc, tbl[i].junk);
      chk($sformatf("tbl%0d.req", i), {31'h0, o_imem_req}, {31'h0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d.addr", i), o_imem_addr, tbl[i].e_addr);
      chk_head($sformatf("tbl%0d", i), tbl[i].e_vld, tbl[i].e_pc);
    end

    // Asynchronous reset mid-operation clears outputs without a clock edge.
    #2 rst = 1'b0; #1;
    chk("midrst.req",  {31'h0, o_imem_req},   32'h0);
    chk("midrst.vld",  {31'h0, o_inst_valid}, 32'h0);
    chk("midrst.inst", o_inst,                32'h0);
    chk("midrst.addr", o_imem_addr,           32'h0);

    // Decode stalled from reset: two credits used, head holds at pc 0, nothing lost on resume.
    do_reset();
    tick(0, 0, 0, 0); chk("stl1.req", {31'h0, o_imem_req}, 32'h1);
    tick(0, 0, 0, 0); chk("stl2.addr", o_imem_addr, 32'h4);
    for (int i = 3; i <= 7; i++) begin
      tick(0, 0, 0, 0);
      chk($sformatf("stl%0d.req", i), {31'h0, o_imem_req}, 32'h0);
      chk_head($sformatf("stl%0d", i), 1'b1, 32'h0);
    end
    tick(1, 0, 0, 0); chk_head("stl8", 1'b1, 32'h0); chk("stl8.addr", o_imem_addr, 32'h8);
    tick(1, 0, 0, 0); chk_head("stl9", 1'b1, 32'h4);
    tick(1, 0, 0, 0); chk_head("stl10", 1'b1, 32'h8);

    // Slow memory: redirect while two requests are in flight; both stale responses are dropped.
    do_reset();
    lat = 3;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 1, 32'h100, 0);
    chk("inf.req", {31'h0, o_imem_req}, 32'h0);
    found = 1'b0; fpc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      tick(1, 0, 0, 0);
      if (o_inst_valid) begin
        chk($sformatf("inf%0d.inst", i), o_inst, mdata(o_inst_pc));
        if (!found) begin found = 1'b1; fpc = o_inst_pc; end
      end
    end
    chk("inf.seen", {31'h0, found}, 32'h1);
    chk("inf.first_pc", fpc, 32'h100);
    lat = 1;

`ifdef FETCH_MISALIGN_EN
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 1, 32'h102, 0);
    for (int i = 4; i <= 6; i++) begin
      tick(1, 0, 0, 0);
      chk($sformatf("mis%0d.flag", i), {31'h0, o_misaligned}, 32'h1);
      chk($sformatf("mis%0d.req", i),  {31'h0, o_imem_req},   32'h0);
      chk($sformatf("mis%0d.vld", i),  {31'h0, o_inst_valid}, 32'h0);
    end
    tick(1, 1, 32'h200, 0);
    tick(1, 0, 0, 0);
    chk("mis8.flag", {31'h0, o_misaligned}, 32'h0);
    chk("mis8.req",  {31'h0, o_imem_req},   32'h1);
    chk("mis8.addr", o_imem_addr,           32'h200);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk_head("mis10", 1'b1, 32'h200);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
